cmp_sweep_checker: RTL and testbench

//  On-chip stimulus/checker for the 2-bit magnitude comparator tile. Drives every
//  A/B pair in order, A outer loop and B inner loop (0..2^W-1 each). Samples the
//  one-hot gt/eq/lt result, counts mismatches and captures the first failing pair.

---
 rtl/cmp_pkg.sv | 16 +
 rtl/cmp_sweep_checker_if.sv | 32 +++
 rtl/cmp_sweep_checker_ref_model.sv | 21 ++
 rtl/cmp_sweep_checker.sv | 123 ++++++++++++
 tb/tb_cmp_sweep_checker.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator sweep checker: FSM state encoding
// and the bit positions of the gt/eq/lt result within a 3-bit vector.
package cmp_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRIVE  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Result bit positions, matching the comparator's uo_out mapping.
  localparam int GT = 0;
  localparam int EQ = 1;
  localparam int LT = 2;

endpackage

// File: rtl/cmp_sweep_checker_if.sv
// Bus between the sweep checker and the comparator tile / project top.
// The master side is the checker; the slave side is the comparator plus
// whatever observes the status outputs.
interface cmp_sweep_checker_if #(
  parameter int WIDTH = 2,
  parameter int ERRW  = 5
);

  logic             start;
  logic [WIDTH-1:0] stim_a;
  logic [WIDTH-1:0] stim_b;
  logic             dut_gt;
  logic             dut_eq;
  logic             dut_lt;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERRW-1:0]  err_count;
  logic [WIDTH-1:0] fail_a;
  logic [WIDTH-1:0] fail_b;

  modport master (
    input  start, dut_gt, dut_eq, dut_lt,
    output stim_a, stim_b, busy, done, pass, err_count, fail_a, fail_b
  );

  modport slave (
    output start, dut_gt, dut_eq, dut_lt,
    input  stim_a, stim_b, busy, done, pass, err_count, fail_a, fail_b
  );

endinterface

// File: rtl/cmp_sweep_checker_ref_model.sv
// Golden unsigned magnitude comparison producing the one-hot gt/eq/lt
// vector. Purely combinational so it can be reused by other benches.
module cmp_ref_model
  import cmp_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       expected
);

  // Expected one-hot comparison result for the current operand pair.
  always_comb begin
    expected     = '0;
    expected[GT] = (a > b);
    expected[EQ] = (a == b);
    expected[LT] = (a < b);
  end

endmodule

// File: rtl/cmp_sweep_checker.sv
// On-chip exhaustive checker for the magnitude comparator tile. Walks every
// A/B pair (A outer, B inner), waits SETTLE cycles per vector, compares the
// comparator's gt/eq/lt against the golden model, counts mismatches with
// saturation and captures the first failing pair.
module cmp_sweep_checker
  import cmp_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1,
  parameter int ERRW   = 5
) (
  input logic                 clk,
  input logic                 rst_n,
  cmp_sweep_checker_if.master bus
);

  localparam int SCW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int VW  = 2 * WIDTH;
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'((SETTLE > 0) ? (SETTLE - 1) : 0);

  logic [2:0]       state_q;
  logic [SCW-1:0]   settle_cnt_q;
  logic [WIDTH-1:0] stim_a_q;
  logic [WIDTH-1:0] stim_b_q;
  logic [ERRW-1:0]  err_count_q;
  logic [WIDTH-1:0] fail_a_q;
  logic [WIDTH-1:0] fail_b_q;

  logic [2:0] expected;
  logic [2:0] observed;
  logic       mismatch;
  logic       last_vector;
  logic       start_sweep;
  logic       in_check;

  cmp_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a        (stim_a_q),
    .b        (stim_b_q),
    .expected (expected)
  );

  // Gather the comparator response and decode the sweep control conditions.
  always_comb begin
    observed     = '0;
    observed[GT] = bus.dut_gt;
    observed[EQ] = bus.dut_eq;
    observed[LT] = bus.dut_lt;
    mismatch     = (observed != expected);
    last_vector  = (stim_a_q == '1) && (stim_b_q == '1);
    start_sweep  = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && bus.start;
    in_check     = (state_q == ST_CHECK);
  end

  // Sequence IDLE/DONE -> DRIVE -> SETTLE -> CHECK, looping until the last vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) state_q <= ST_DRIVE;
        end
        ST_DRIVE: begin
          settle_cnt_q <= '0;
          if (SETTLE == 0) state_q <= ST_CHECK;
          else             state_q <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) state_q <= ST_CHECK;
          else                             settle_cnt_q <= settle_cnt_q + SCW'(1);
        end
        ST_CHECK: begin
          if (last_vector) state_q <= ST_DONE;
          else             state_q <= ST_DRIVE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Operand counter: B is the low half so it wraps into an A increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim_a_q <= '0;
      stim_b_q <= '0;
    end else if (start_sweep) begin
      stim_a_q <= '0;
      stim_b_q <= '0;
    end else if (in_check && !last_vector) begin
      {stim_a_q, stim_b_q} <= {stim_a_q, stim_b_q} + VW'(1);
    end
  end

  // Saturating mismatch count and first-failure capture, cleared per sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= '0;
      fail_a_q    <= '0;
      fail_b_q    <= '0;
    end else if (start_sweep) begin
      err_count_q <= '0;
      fail_a_q    <= '0;
      fail_b_q    <= '0;
    end else if (in_check && mismatch) begin
      if (err_count_q != '1) err_count_q <= err_count_q + ERRW'(1);
      if (err_count_q == '0) begin
        fail_a_q <= stim_a_q;
        fail_b_q <= stim_b_q;
      end
    end
  end

  assign bus.stim_a    = stim_a_q;
  assign bus.stim_b    = stim_b_q;
  assign bus.busy      = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.pass      = (state_q == ST_DONE) && (err_count_q == '0);
  assign bus.err_count = err_count_q;
  assign bus.fail_a    = fail_a_q;
  assign bus.fail_b    = fail_b_q;

endmodule

// File: tb/tb_cmp_sweep_checker.sv
// Bench for cmp_sweep_checker: three instances (defaults, ERRW=3, SETTLE=0)
// each facing a table-driven comparator whose response per A/B pair is set
// by the bench (golden, stuck, swapped, all-zero or randomly corrupted).
module tb_cmp_sweep_checker;
  import cmp_pkg::*;

  typedef logic [2:0] table_t [16];

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  table_t resp0;
  table_t resp1;
  table_t resp2;

  cmp_sweep_checker_if #(.WIDTH(2), .ERRW(5)) i0 ();
  cmp_sweep_checker_if #(.WIDTH(2), .ERRW(3)) i1 ();
  cmp_sweep_checker_if #(.WIDTH(2), .ERRW(5)) i2 ();

  cmp_sweep_checker #(.WIDTH(2), .SETTLE(1), .ERRW(5)) dut0 (.clk(clk), .rst_n(rst_n), .bus(i0));
  cmp_sweep_checker #(.WIDTH(2), .SETTLE(1), .ERRW(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(i1));
  cmp_sweep_checker #(.WIDTH(2), .SETTLE(0), .ERRW(5)) dut2 (.clk(clk), .rst_n(rst_n), .bus(i2));

  // Table-driven comparator models, indexed by {A,B}.
  assign i0.dut_gt = resp0[{i0.stim_a, i0.stim_b}][GT];
  assign i0.dut_eq = resp0[{i0.stim_a, i0.stim_b}][EQ];
  assign i0.dut_lt = resp0[{i0.stim_a, i0.stim_b}][LT];
  assign i1.dut_gt = resp1[{i1.stim_a, i1.stim_b}][GT];
  assign i1.dut_eq = resp1[{i1.stim_a, i1.stim_b}][EQ];
  assign i1.dut_lt = resp1[{i1.stim_a, i1.stim_b}][LT];
  assign i2.dut_gt = resp2[{i2.stim_a, i2.stim_b}][GT];
  assign i2.dut_eq = resp2[{i2.stim_a, i2.stim_b}][EQ];
  assign i2.dut_lt = resp2[{i2.stim_a, i2.stim_b}][LT];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] ideal(input int a, input int b);
    logic [2:0] r;
    r     = '0;
    r[GT] = (a > b);
    r[EQ] = (a == b);
    r[LT] = (a < b);
    return r;
  endfunction

  // Expected sweep outcome from walking the response table in sweep order.
  task automatic modelSweep(input table_t tbl, input int errmax,
                            output int errs, output int fa, output int fb);
    errs = 0; fa = 0; fb = 0;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        if (tbl[a*4 + b] !== ideal(a, b)) begin
          if (errs == 0) begin fa = a; fb = b; end
          if (errs < errmax) errs++;
        end
      end
    end
  endtask

  // Build a comparator response table: 0 golden, 1 gt stuck high, 2 gt/lt swapped,
  // 3 all outputs zero, 4 randomly corrupted.
  task automatic applyStimulus(input int mode, output table_t tbl);
    logic [2:0] g;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        g = ideal(a, b);
        case (mode)
          1: g[GT] = 1'b1;
          2: g = {g[GT], g[EQ], g[LT]};
          3: g = 3'b000;
          4: if ($urandom_range(0, 3) == 0) g = 3'($urandom_range(0, 7));
          default: ;
        endcase
        tbl[a*4 + b] = g;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One sweep on dut0; optionally toggles start randomly while busy.
  task automatic runSweep0(input bit glitch, output int busy_cycles, output bit timed_out);
    int n;
    @(negedge clk); i0.start = 1'b1;
    @(negedge clk); i0.start = 1'b0;
    busy_cycles = 0; n = 0;
    while (!i0.done && n < 2000) begin
      if (i0.busy) busy_cycles++;
      if (glitch) i0.start = i0.busy ? 1'($urandom_range(0, 1)) : 1'b0;
      n++;
      @(negedge clk);
    end
    i0.start  = 1'b0;
    timed_out = !i0.done;
  endtask

  task automatic checkSweep0(input string tag, input bit glitch);
    int cyc, errs, fa, fb;
    bit to;
    runSweep0(glitch, cyc, to);
    modelSweep(resp0, 31, errs, fa, fb);
    checkOutput({tag, "_timeout"}, 32'(to), 0);
    checkOutput({tag, "_busy_cycles"}, cyc, 16 * (1 + 2));
    checkOutput({tag, "_done"}, 32'(i0.done), 1);
    checkOutput({tag, "_pass"}, 32'(i0.pass), 32'(errs == 0));
    checkOutput({tag, "_err_count"}, 32'(i0.err_count), errs);
    checkOutput({tag, "_fail_a"}, 32'(i0.fail_a), fa);
    checkOutput({tag, "_fail_b"}, 32'(i0.fail_b), fb);
    checkOutput({tag, "_stim_hold"}, 32'({i0.stim_a, i0.stim_b}), 15);
  endtask

  task automatic checkZero0(input string tag);
    checkOutput({tag, "_busy"}, 32'(i0.busy), 0);
    checkOutput({tag, "_done"}, 32'(i0.done), 0);
    checkOutput({tag, "_pass"}, 32'(i0.pass), 0);
    checkOutput({tag, "_err_count"}, 32'(i0.err_count), 0);
    checkOutput({tag, "_fail"}, 32'({i0.fail_a, i0.fail_b}), 0);
    checkOutput({tag, "_stim"}, 32'({i0.stim_a, i0.stim_b}), 0);
  endtask

  initial begin
    int n, cyc, errs, fa, fb;
    checks = 0; failures = 0;
    rst_n = 1'b0;
    i0.start = 1'b0; i1.start = 1'b0; i2.start = 1'b0;
    applyStimulus(0, resp0); applyStimulus(0, resp1); applyStimulus(0, resp2);

    // Reset state.
    #12;
    checkZero0("reset");
    @(negedge clk); rst_n = 1'b1;

    // Golden, stuck gt, swapped gt/lt, then random corruption.
    applyStimulus(0, resp0); checkSweep0("golden", 1'b0);
    applyStimulus(1, resp0); checkSweep0("gt_stuck", 1'b0);
    applyStimulus(2, resp0); checkSweep0("swapped", 1'b0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4, resp0); checkSweep0($sformatf("random%0d", k), 1'b0);
    end

    // start pulses while busy must not disturb the sweep.
    applyStimulus(4, resp0); checkSweep0("start_glitch", 1'b1);

    // All-zero outputs against a 3-bit error counter saturate.
    applyStimulus(3, resp1);
    @(negedge clk); i1.start = 1'b1;
    @(negedge clk); i1.start = 1'b0;
    n = 0;
    while (!i1.done && n < 2000) begin n++; @(negedge clk); end
    modelSweep(resp1, 7, errs, fa, fb);
    checkOutput("sat_done", 32'(i1.done), 1);
    checkOutput("sat_err_count", 32'(i1.err_count), errs);
    checkOutput("sat_fail", 32'({i1.fail_a, i1.fail_b}), {fa[1:0], fb[1:0]});
    checkOutput("sat_pass", 32'(i1.pass), 0);

    // Reset in the middle of a faulty sweep clears everything immediately.
    applyStimulus(1, resp0);
    @(negedge clk); i0.start = 1'b1;
    @(negedge clk); i0.start = 1'b0;
    n = 0;
    while (!(i0.stim_a == 2'd2 && i0.stim_b == 2'd1) && n < 2000) begin n++; @(negedge clk); end
    checkOutput("midreset_reached", 32'(n < 2000), 1);
    rst_n = 1'b0;
    #1;
    checkZero0("midreset");
    @(negedge clk); rst_n = 1'b1;
    applyStimulus(0, resp0); checkSweep0("after_reset", 1'b0);

    // SETTLE=0 with start held in DONE: back-to-back sweeps, counters cleared.
    applyStimulus(3, resp2);
    @(negedge clk); i2.start = 1'b1;
    @(negedge clk);
    cyc = 0; n = 0;
    while (!i2.done && n < 2000) begin if (i2.busy) cyc++; n++; @(negedge clk); end
    modelSweep(resp2, 31, errs, fa, fb);
    checkOutput("held_first_cycles", cyc, 16 * 2);
    checkOutput("held_first_err", 32'(i2.err_count), errs);
    applyStimulus(0, resp2);
    @(negedge clk);
    checkOutput("held_restart_busy", 32'(i2.busy), 1);
    checkOutput("held_restart_err", 32'(i2.err_count), 0);
    i2.start = 1'b0;
    cyc = 0; n = 0;
    while (!i2.done && n < 2000) begin if (i2.busy) cyc++; n++; @(negedge clk); end
    checkOutput("held_second_cycles", cyc, 16 * 2);
    checkOutput("held_second_pass", 32'(i2.pass), 1);
    checkOutput("held_second_err", 32'(i2.err_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
